// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters
module alu_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [4:0]       req0_ctr,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [4:0]       req0_shamt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [4:0]       req1_ctr,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [4:0]       req1_shamt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [4:0]       ALUctr,
    output logic [31:0]      busA,
    output logic [31:0]      tempBus,
    output logic [4:0]       shamt,
    input  logic [31:0]      Result,
    input  logic             Zero,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nx;
    logic rr_last, grant, accept, illegal;

    // Grant selection, handshakes, opcode check and next-state decode
    always_comb begin
        grant = (req0_valid && req1_valid) ? ((FIXED_PRIO != 0) ? 1'b0 : ~rr_last) : req1_valid;
        req0_ready = (state == IDLE) && req0_valid && !grant;
        req1_ready = (state == IDLE) && req1_valid && grant;
        accept = req0_ready || req1_ready;
        rsp_valid = (state == RESP);
        illegal = (ALUctr == 5'b01010) || (ALUctr == 5'b01011) || (ALUctr >= 5'b10001);
        state_nx = (state == IDLE) ? (accept ? EXEC : IDLE) :
                   (state == EXEC) ? RESP :
                   (state == RESP) ? (rsp_ready ? IDLE : RESP) : IDLE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // ALU operand registers load only on accept; rr_last doubles as the in-flight id
    always_ff @(posedge clk) begin
        if (rst) begin
            ALUctr  <= '0;
            busA    <= '0;
            tempBus <= '0;
            shamt   <= '0;
            rr_last <= 1'b1;
        end else if (accept) begin
            ALUctr  <= grant ? req1_ctr : req0_ctr;
            busA    <= grant ? req1_a : req0_a;
            tempBus <= grant ? req1_b : req0_b;
            shamt   <= grant ? req1_shamt : req0_shamt;
            rr_last <= grant;
        end
    end

    // Response capture at the end of EXEC and saturating completion count
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_id     <= 1'b0;
            op_count   <= '0;
        end else begin
            if (state == EXEC) begin
                rsp_result <= illegal ? 32'd0 : Result;
                rsp_zero   <= !illegal && Zero;
                rsp_err    <= illegal;
                rsp_id     <= rr_last;
            end
            if (rsp_valid && rsp_ready && op_count != '1) op_count <= op_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of round-robin and fixed-priority arbiter instances
module tb_alu_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, req0_valid, req1_valid, rsp_ready;
    logic [4:0] req0_ctr, req1_ctr, req0_shamt, req1_shamt;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;

    logic r_req0_ready, r_req1_ready, r_rsp_valid, r_rsp_id, r_rsp_zero, r_rsp_err, r_Zero;
    logic [31:0] r_rsp_result, r_busA, r_tempBus, r_Result;
    logic [4:0] r_ALUctr, r_shamt;
    logic [15:0] r_op_count;
    logic f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_rsp_zero, f_rsp_err, f_Zero;
    logic [31:0] f_rsp_result, f_busA, f_tempBus, f_Result;
    logic [4:0] f_ALUctr, f_shamt;
    logic [15:0] f_op_count;

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [31:0] alu(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
        logic signed [31:0] sb;
        sb = b;
        if (c == 5'b00000) return a + b;
        if (c == 5'b00001) return a - b;
        if (c == 5'b01101) return sb >>> s;
        return 32'hDEADBEEF;
    endfunction

    assign r_Result = alu(r_ALUctr, r_busA, r_tempBus, r_shamt);
    assign r_Zero = (r_Result == 32'd0);
    assign f_Result = alu(f_ALUctr, f_busA, f_tempBus, f_shamt);
    assign f_Zero = (f_Result == 32'd0);

    alu_arbiter #(.FIXED_PRIO(0), .CNT_W(16)) u_rr (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(r_req0_ready), .req0_ctr(req0_ctr),
        .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(r_req1_ready), .req1_ctr(req1_ctr),
        .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
        .rsp_valid(r_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(r_rsp_id),
        .rsp_result(r_rsp_result), .rsp_zero(r_rsp_zero), .rsp_err(r_rsp_err),
        .ALUctr(r_ALUctr), .busA(r_busA), .tempBus(r_tempBus), .shamt(r_shamt),
        .Result(r_Result), .Zero(r_Zero), .op_count(r_op_count)
    );

    alu_arbiter #(.FIXED_PRIO(1), .CNT_W(16)) u_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_ctr(req0_ctr),
        .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_ctr(req1_ctr),
        .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
        .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(f_rsp_id),
        .rsp_result(f_rsp_result), .rsp_zero(f_rsp_zero), .rsp_err(f_rsp_err),
        .ALUctr(f_ALUctr), .busA(f_busA), .tempBus(f_tempBus), .shamt(f_shamt),
        .Result(f_Result), .Zero(f_Zero), .op_count(f_op_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_ctr = '0; req0_a = '0; req0_b = '0; req0_shamt = '0;
        req1_valid = 1'b0; req1_ctr = '0; req1_a = '0; req1_b = '0; req1_shamt = '0;
        repeat (2) tick();
        check("rst_rsp_valid", 32'(r_rsp_valid), 32'd0);
        check("rst_op_count", 32'(r_op_count), 32'd0);
        check("rst_aluctr", 32'(r_ALUctr), 32'd0);
        check("rst_busa", r_busA, 32'd0);
        check("rst_result", r_rsp_result, 32'd0);
        rst = 1'b0;

        req0_valid = 1'b1; req0_ctr = 5'b00000; req0_a = 32'd5; req0_b = 32'd7;
        #1;
        check("single_ready0", 32'(r_req0_ready), 32'd1);
        check("single_ready1", 32'(r_req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("exec_rsp_valid", 32'(r_rsp_valid), 32'd0);
        check("exec_aluctr", 32'(r_ALUctr), 32'd0);
        check("exec_busa", r_busA, 32'd5);
        check("exec_tempbus", r_tempBus, 32'd7);
        tick();
        check("single_valid", 32'(r_rsp_valid), 32'd1);
        check("single_result", r_rsp_result, 32'd12);
        check("single_zero", 32'(r_rsp_zero), 32'd0);
        check("single_id", 32'(r_rsp_id), 32'd0);
        check("single_err", 32'(r_rsp_err), 32'd0);
        rsp_ready = 1'b1;
        tick();
        check("single_drop", 32'(r_rsp_valid), 32'd0);
        check("single_count", 32'(r_op_count), 32'd1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_count", 32'(r_op_count), 32'd0);
        req0_ctr = 5'b00000; req0_a = 32'd1; req0_b = 32'd2;
        req1_ctr = 5'b00001; req1_a = 32'd10; req1_b = 32'd4;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ready0", 32'(r_req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_ready1", 32'(r_req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            check("fp_ready0", 32'(f_req0_ready), 32'd1);
            check("fp_ready1", 32'(f_req1_ready), 32'd0);
            tick();
            tick();
            check("rr_id", 32'(r_rsp_id), (i % 2 == 1) ? 32'd1 : 32'd0);
            check("rr_result", r_rsp_result, (i % 2 == 1) ? 32'd6 : 32'd3);
            check("fp_id", 32'(f_rsp_id), 32'd0);
            check("fp_result", f_rsp_result, 32'd3);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_count4", 32'(r_op_count), 32'd4);
        check("fp_count4", 32'(f_op_count), 32'd4);

        rsp_ready = 1'b0;
        req0_ctr = 5'b00001; req0_a = 32'd3; req0_b = 32'd3; req0_valid = 1'b1;
        #1;
        check("bp_ready0", 32'(r_req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b1;
        #1;
        check("bp_exec_ready1", 32'(r_req1_ready), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(r_rsp_valid), 32'd1);
            check("bp_result", r_rsp_result, 32'd0);
            check("bp_zero", 32'(r_rsp_zero), 32'd1);
            check("bp_ready0", 32'(r_req0_ready), 32'd0);
            check("bp_ready1", 32'(r_req1_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_idle_valid", 32'(r_rsp_valid), 32'd0);
        check("bp_idle_ready1", 32'(r_req1_ready), 32'd1);
        check("bp_count", 32'(r_op_count), 32'd5);
        req1_valid = 1'b0;

        req0_ctr = 5'b01011; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        check("ill_valid", 32'(r_rsp_valid), 32'd1);
        check("ill_err", 32'(r_rsp_err), 32'd1);
        check("ill_result", r_rsp_result, 32'd0);
        check("ill_zero", 32'(r_rsp_zero), 32'd0);
        tick();
        check("ill_count", 32'(r_op_count), 32'd6);

        req0_ctr = 5'b01101; req0_b = 32'h80000000; req0_shamt = 5'd4; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        check("sra_shamt", 32'(r_shamt), 32'd4);
        check("sra_aluctr", 32'(r_ALUctr), 32'd13);
        tick();
        check("sra_result", r_rsp_result, 32'hF8000000);
        check("sra_err", 32'(r_rsp_err), 32'd0);
        check("sra_zero", 32'(r_rsp_zero), 32'd0);
        tick();
        check("sra_count", 32'(r_op_count), 32'd7);

        rsp_ready = 1'b0;
        req1_ctr = 5'b00000; req1_a = 32'd100; req1_b = 32'd23; req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0;
        check("rexec_busa", r_busA, 32'd100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rexec_valid", 32'(r_rsp_valid), 32'd0);
        check("rexec_aluctr", 32'(r_ALUctr), 32'd0);
        check("rexec_busa0", r_busA, 32'd0);
        check("rexec_count", 32'(r_op_count), 32'd0);
        tick();
        check("rexec_no_rsp", 32'(r_rsp_valid), 32'd0);

        req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0;
        tick();
        check("rresp_valid", 32'(r_rsp_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rresp_valid0", 32'(r_rsp_valid), 32'd0);
        check("rresp_result0", r_rsp_result, 32'd0);
        check("rresp_id0", 32'(r_rsp_id), 32'd0);
        check("rresp_busa0", r_busA, 32'd0);

        rsp_ready = 1'b1; req1_valid = 1'b1;
        #1;
        check("after_ready1", 32'(r_req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        check("after_valid", 32'(r_rsp_valid), 32'd1);
        check("after_id", 32'(r_rsp_id), 32'd1);
        check("after_result", r_rsp_result, 32'd123);
        tick();
        check("after_count", 32'(r_op_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
